usb_in_arbiter: RTL and testbench
=================================

// Module: usb_in_arbiter
// PURPOSE
// - Shares the usb_cdc bulk IN byte stream (in_data/in_valid/in_ready, app clock domain) among N_REQ SoC sources.
// - Round-robin grant with burst locking: a granted source keeps the channel until its message ends, so bytes never interleave.
// - Sits between SoC byte producers (console, loopback echo, status reporter) and the u_usb_cdc IN application port.
// PARAMETERS
// - N_REQ         2   number of requesters, 2..4
// - MAX_BURST     8   max bytes per grant; matches IN_BULK_MAXPACKETSIZE
// - IDLE_TIMEOUT  16  consecutive cycles of holder valid low before the grant is revoked; >=1
// PORTS
// - clk_i          in   1          application clock
// - rst_i          in   1          synchronous reset, active-high
// - req_data_i     in   8*N_REQ    byte from requester k at [8k+7:8k]
// - req_valid_i    in   N_REQ      requester k has a byte
// - req_last_i     in   N_REQ      byte on requester k ends its message
// - req_ready_o    out  N_REQ      byte of requester k accepted this cycle when valid&ready
// - in_data_o      out  8          to usb_cdc in_data_i
// - in_valid_o     out  1          to usb_cdc in_valid_i
// - in_ready_i     in   1          from usb_cdc in_ready_o
// - grant_o        out  N_REQ      one-hot current owner; 0 when idle
// BEHAVIOUR
// - Reset: in_valid_o=0, in_data_o=8'h00, req_ready_o=0, grant_o=0, state=ST_IDLE, rr pointer=N_REQ-1 (req 0 wins first).
// - Output stage: one registered slot. slot_free = ~in_valid_o | in_ready_i.
//   req_ready_o[k] = grant_o[k] & slot_free (state ST_GRANT only). On accept, in_data_o<=byte, in_valid_o<=1 next cycle.
//   No accept and in_ready_i=1 -> in_valid_o<=0. in_data_o holds while in_valid_o & ~in_ready_i.
// - FSM ST_IDLE -> ST_GRANT: any req_valid_i set; winner = first set index after rr pointer (wrapping);
//   grant_o registered, so first accept of the winner is the cycle after arbitration (1-cycle arbitration latency).
//   rr pointer <= winner at grant time.
// - ST_GRANT -> ST_IDLE when any of: accepted byte has req_last_i; burst counter reaches MAX_BURST on accept;
//   idle counter reaches IDLE_TIMEOUT. grant_o<=0 in the same edge; re-arbitration next cycle.
// - Burst counter: $clog2(MAX_BURST+1) bits, cleared on grant, +1 per accept; last and MAX_BURST on the same byte = one release.
// - Idle counter: cleared on grant and on every cycle holder valid=1; +1 while holder valid=0; saturates.
//   Holder valid=1 but slot full (backpressure) is NOT idle.
// - Non-holders see req_ready_o=0 regardless of valid; their data must stay stable (AXI-style, no drop).
// - Release never waits for the output slot to drain; the next owner's first byte queues behind it in order.
// - Single requester: releases after MAX_BURST then regrants itself after the 1-cycle ST_IDLE gap.
// - Reset mid-burst: slot byte is discarded, in_valid_o drops on the next edge; no partial state survives.
// - in_ready_i when in_valid_o=0 is ignored.
// STRUCTURE
// - Shared package usb_soc_pkg: ST_IDLE/ST_GRANT state encoding, ARB_MAX_REQ=4.
// - Sub-module rr_pick (combinational: req vector + pointer -> one-hot winner); rest in this file.
// TESTING
// - Req0 sends 7 bytes 01..07 with last on 07, in_ready_i=1: in_data_o 01..07 back-to-back, grant_o=01 throughout, then 00.
// - Req0 and req1 valid from reset, 16 bytes each, no last: order 8 of req0, 8 of req1, 8 of req0, 8 of req1.
// - Req1 streaming while req0 message 11..18 with last; in_ready_i toggled 1/0: no byte lost/duplicated, no interleave within a burst.
// - Req0 granted, valid drops after 3 bytes for 16 cycles: grant revoked at cycle 16, pending req1 granted next.
// - in_ready_i held 0 for 40 cycles mid-burst: in_data_o stable, req_ready_o=0, grant kept (no timeout).
// - rst_i pulsed with in_valid_o=1 mid-burst: in_valid_o=0, grant_o=0 next cycle; req0 wins next arbitration.

Source files
------------

// File: rtl/usb_soc_pkg.sv
// Shared SoC USB definitions: IN-arbiter state encoding and requester limit.
package usb_soc_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int ARB_MAX_REQ = 4;

endpackage

// File: rtl/usb_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping to the lowest index; returns a one-hot winner.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_hi;
    logic [N_REQ-1:0] w_sel;

    for (genvar g = 0; g < N_REQ; g++) begin : g_mask
        assign w_mask[g] = (PW'(g) > i_ptr);
    end

    // Prefer requests above the pointer; otherwise wrap to the whole vector.
    assign w_hi    = i_req & w_mask;
    assign w_sel   = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_sel & (~w_sel + N_REQ'(1));

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin, burst-locked arbiter sharing the usb_cdc bulk IN byte stream
// among N_REQ producers, with a single registered output slot.
module usb_in_arbiter
    import usb_soc_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic [N_REQ-1:0]   grant_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [0:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic [BW-1:0]    r_burst;
    logic [IW-1:0]    r_idle;
    logic [7:0]       r_data;
    logic             r_valid;

    logic [N_REQ-1:0] w_pick;
    logic [PW-1:0]    w_pick_idx;
    logic [N_REQ-1:0] w_ready;
    logic [7:0]       w_byte;
    logic [BW-1:0]    w_burst_nxt;
    logic             w_slot_free;
    logic             w_acc;
    logic             w_acc_last;
    logic             w_holder_valid;
    logic             w_release;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick[k]) w_pick_idx = PW'(k);
        end
    end

    always_comb begin
        w_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) w_byte = req_data_i[8*k +: 8];
        end
    end

    assign w_slot_free    = ~r_valid | in_ready_i;
    assign w_ready        = (r_state == ST_GRANT) ? (r_grant & {N_REQ{w_slot_free}}) : '0;
    assign w_acc          = |(w_ready & req_valid_i);
    assign w_acc_last     = |(w_ready & req_valid_i & req_last_i);
    assign w_holder_valid = |(r_grant & req_valid_i);
    assign w_burst_nxt    = r_burst + BW'(1);

    // Backpressure with holder valid high never counts as idle time.
    assign w_release = (w_acc && (w_acc_last || (w_burst_nxt == BW'(MAX_BURST)))) ||
                       (!w_holder_valid && (r_idle == IW'(IDLE_TIMEOUT - 1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(N_REQ - 1);
            r_grant <= '0;
            r_burst <= '0;
            r_idle  <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            if (w_acc) begin
                r_data  <= w_byte;
                r_valid <= 1'b1;
            end else if (in_ready_i) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_pick;
                        r_ptr   <= w_pick_idx;
                        r_burst <= '0;
                        r_idle  <= '0;
                    end
                end
                default: begin
                    if (w_acc) r_burst <= w_burst_nxt;
                    if (w_holder_valid) begin
                        r_idle <= '0;
                    end else if (r_idle != IW'(IDLE_TIMEOUT)) begin
                        r_idle <= r_idle + IW'(1);
                    end
                    // Release does not wait for the slot; the next owner queues behind it.
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = w_ready;
    assign in_data_o   = r_data;
    assign in_valid_o  = r_valid;
    assign grant_o     = r_grant;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Bench for usb_in_arbiter: queue-based sources, a behavioural arbiter model
// compared every cycle, directed scenarios and a randomized soak.
module tb_usb_in_arbiter;

    localparam int N  = 3;
    localparam int MB = 8;
    localparam int IT = 16;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic [7:0]     in_data_o;
    logic           in_valid_o;
    logic           in_ready_i;
    logic [N-1:0]   grant_o;

    always #5 clk_i = ~clk_i;

    usb_in_arbiter #(.N_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .grant_o     (grant_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] q_data [N][$];
    bit         q_last [N][$];
    bit         pres   [N];
    int         stall  [N];
    bit         fired  [N];
    bit         rand_mode = 1'b0;

    logic [7:0] out_log [$];
    int         out_cyc [$];

    // Model: owner index (-1 idle), rr pointer, per-grant byte and idle counts, output slot.
    int         m_owner, m_ptr, m_cnt, m_idle;
    bit         m_valid;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] r;
        r = '0;
        if (o >= 0) r[o] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_cnt   = 0;
        m_idle  = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    task automatic model_step();
        bit slot_free, acc, rel;
        int o;
        if (rst_i) begin
            model_reset();
            return;
        end
        slot_free = !m_valid || in_ready_i;
        acc = (m_owner >= 0) && slot_free && req_valid_i[m_owner];
        rel = 1'b0;
        if (acc) begin
            m_data  = req_data_i[8*m_owner +: 8];
            m_valid = 1'b1;
        end else if (in_ready_i) begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                o = (m_ptr + i) % N;
                if (req_valid_i[o]) begin
                    m_owner = o;
                    m_ptr   = o;
                    m_cnt   = 0;
                    m_idle  = 0;
                    break;
                end
            end
        end else begin
            if (acc) begin
                m_cnt++;
                if (req_last_i[m_owner] || m_cnt == MB) rel = 1'b1;
            end
            if (req_valid_i[m_owner]) m_idle = 0;
            else m_idle++;
            if (m_idle >= IT) rel = 1'b1;
            if (rel) m_owner = -1;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (stall[k] > 0) begin
                stall[k]--;
            end else if (!pres[k] && q_data[k].size() > 0) begin
                if (!rand_mode) pres[k] = 1'b1;
                else if ($urandom_range(0, 40) == 0) stall[k] = int'($urandom_range(10, 24));
                else if ($urandom_range(0, 3) != 0) pres[k] = 1'b1;
            end
            req_valid_i[k]       = pres[k];
            req_data_i[8*k +: 8] = pres[k] ? q_data[k][0] : 8'h00;
            req_last_i[k]        = pres[k] ? q_last[k][0] : 1'b0;
        end
    endtask

    task automatic load(input int k, input logic [7:0] d, input bit l);
        q_data[k].push_back(d);
        q_last[k].push_back(l);
    endtask

    task automatic cycle();
        logic [N-1:0] exp_ready;
        @(negedge clk_i);
        exp_ready = (m_owner >= 0 && (!m_valid || in_ready_i)) ? onehot(m_owner) : '0;
        chk("grant_o",     32'(grant_o),     32'(onehot(m_owner)));
        chk("in_valid_o",  32'(in_valid_o),  32'(m_valid));
        chk("in_data_o",   32'(in_data_o),   32'(m_data));
        chk("req_ready_o", 32'(req_ready_o), 32'(exp_ready));
        for (int k = 0; k < N; k++) fired[k] = req_valid_i[k] && req_ready_o[k];
        if (in_valid_o && in_ready_i) begin
            out_log.push_back(in_data_o);
            out_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (fired[k]) begin
                void'(q_data[k].pop_front());
                void'(q_last[k].pop_front());
                pres[k] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic reset_all();
        rst_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            q_data[k].delete();
            q_last[k].delete();
            pres[k]  = 1'b0;
            stall[k] = 0;
        end
        drive();
        @(posedge clk_i);
        #1;
        cyc++;
        model_reset();
        rst_i = 1'b0;
        out_log.delete();
        out_cyc.delete();
    endtask

    initial begin
        logic [N-1:0] nxt;
        logic [7:0]   d;
        int           n, idle_n, idx, bad;
        bit           seen;

        rst_i       = 1'b1;
        in_ready_i  = 1'b1;
        req_data_i  = '0;
        req_valid_i = '0;
        req_last_i  = '0;

        // Reset state and a single 7-byte message.
        reset_all();
        chk("rst_grant",     32'(grant_o),     32'(0));
        chk("rst_in_valid",  32'(in_valid_o),  32'(0));
        chk("rst_in_data",   32'(in_data_o),   32'(0));
        chk("rst_req_ready", 32'(req_ready_o), 32'(0));
        for (int j = 0; j < 7; j++) load(0, 8'(j + 1), j == 6);
        drive();
        repeat (12) cycle();
        chk("s1_count", 32'(out_log.size()), 32'(7));
        if (out_log.size() == 7) begin
            for (int j = 0; j < 7; j++) chk("s1_byte", 32'(out_log[j]), 32'(j + 1));
            chk("s1_b2b", 32'(out_cyc[6] - out_cyc[0]), 32'(6));
        end
        chk("s1_grant_end", 32'(grant_o), 32'(0));

        // Two streams without last: alternating bursts of MAX_BURST.
        reset_all();
        for (int j = 0; j < 16; j++) begin
            load(0, 8'(j), 1'b0);
            load(1, 8'(8'h80 + j), 1'b0);
        end
        drive();
        repeat (50) cycle();
        chk("s2_count", 32'(out_log.size()), 32'(32));
        if (out_log.size() == 32) begin
            for (int b = 0; b < 4; b++)
                for (int j = 0; j < 8; j++)
                    chk("s2_order", 32'(out_log[b*8+j]), 32'(((b % 2) ? 8'h80 : 8'h00) + (b / 2) * 8 + j));
        end

        // Req1 streaming, req0 message 11..18, in_ready toggling.
        reset_all();
        for (int j = 0; j < 32; j++) load(1, 8'(8'hA0 + j), 1'b0);
        drive();
        repeat (5) cycle();
        for (int j = 0; j < 8; j++) load(0, 8'(8'h11 + j), j == 7);
        drive();
        for (int c = 0; c < 200; c++) begin
            in_ready_i = ~in_ready_i;
            cycle();
        end
        in_ready_i = 1'b1;
        repeat (20) cycle();
        chk("s3_count", 32'(out_log.size()), 32'(40));
        idx = -1;
        bad = 0;
        n   = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] == 8'h11 && idx < 0) idx = i;
            if (out_log[i] >= 8'hA0) begin
                if (out_log[i] != 8'(8'hA0 + n)) bad++;
                n++;
            end
        end
        chk("s3_found", 32'(idx >= 0 && idx + 8 <= out_log.size()), 32'(1));
        if (idx >= 0 && idx + 8 <= out_log.size())
            for (int j = 0; j < 8; j++) chk("s3_burst", 32'(out_log[idx+j]), 32'(8'h11 + j));
        chk("s3_req1_order", 32'(bad), 32'(0));

        // Holder goes quiet: revoked after IDLE_TIMEOUT cycles, pending req1 next.
        reset_all();
        for (int j = 0; j < 3; j++) load(0, 8'(8'h21 + j), 1'b0);
        for (int j = 0; j < 4; j++) load(1, 8'(8'hC0 + j), 1'b0);
        drive();
        idle_n = 0;
        seen   = 1'b0;
        nxt    = '0;
        for (int c = 0; c < 80; c++) begin
            cycle();
            if (grant_o == 3'b001 && !req_valid_i[0]) idle_n++;
            if (grant_o == 3'b001) seen = 1'b1;
            else if (seen && grant_o != '0 && nxt == '0) nxt = grant_o;
        end
        chk("s4_idle_len", 32'(idle_n), 32'(16));
        chk("s4_next",     32'(nxt),    32'(3'b010));

        // Long backpressure mid-burst: data held, no ready, no timeout.
        reset_all();
        for (int j = 0; j < 8; j++) load(0, 8'(8'h31 + j), j == 7);
        drive();
        n = 0;
        while (out_log.size() < 3 && n < 30) begin
            cycle();
            n++;
        end
        chk("s5_reach", 32'(out_log.size() >= 3), 32'(1));
        in_ready_i = 1'b0;
        d = in_data_o;
        repeat (40) cycle();
        chk("s5_data",  32'(in_data_o),   32'(d));
        chk("s5_grant", 32'(grant_o),     32'(3'b001));
        chk("s5_valid", 32'(in_valid_o),  32'(1));
        chk("s5_ready", 32'(req_ready_o), 32'(0));
        in_ready_i = 1'b1;
        repeat (20) cycle();
        chk("s5_count", 32'(out_log.size()), 32'(8));
        if (out_log.size() == 8)
            for (int j = 0; j < 8; j++) chk("s5_byte", 32'(out_log[j]), 32'(8'h31 + j));

        // Reset pulse mid-burst.
        reset_all();
        for (int j = 0; j < 8; j++) begin
            load(0, 8'(8'h41 + j), 1'b0);
            load(1, 8'(8'h51 + j), 1'b0);
        end
        drive();
        n = 0;
        while (out_log.size() < 2 && n < 30) begin
            cycle();
            n++;
        end
        chk("s6_pre_valid", 32'(in_valid_o), 32'(1));
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("s6_valid", 32'(in_valid_o), 32'(0));
        chk("s6_grant", 32'(grant_o),    32'(0));
        n = 0;
        while (grant_o == '0 && n < 10) begin
            cycle();
            n++;
        end
        chk("s6_rewin", 32'(grant_o), 32'(3'b001));

        // Randomized soak against the model.
        reset_all();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            in_ready_i = ($urandom_range(0, 9) < 7);
            rst_i      = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < N; k++)
                if (q_data[k].size() < 6 && $urandom_range(0, 2) == 0)
                    load(k, 8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
            cycle();
        end
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
